// File: rtl/seq_pkg.sv
// Shared types and control encodings for the fetch sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    FETCH_L,
    FETCH_H,
    EXEC,
    HALT
  } state_t;

  localparam logic [2:0] ARF_SEL_PC_ONLY = 3'b011;
  localparam logic [2:0] ARF_SEL_NONE    = 3'b111;
  localparam logic [1:0] ARF_FUN_INC     = 2'b01;
  localparam logic [1:0] ARF_OUTD_PC     = 2'b00;
  localparam logic       MEM_CS_ACTIVE   = 1'b0;
  localparam logic       MEM_RD          = 1'b0;

endpackage

// File: rtl/sequence_counter.sv
// One-hot timing step register: clear to T[0], hold, or shift left.
module sequence_counter #(
  parameter int unsigned W = 12
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         hold_i,
  input  logic         advance_i,
  output logic [W-1:0] t_o,
  output logic         at_last_o
);

  logic [W-1:0] t_q, t_d;

  always_comb begin
    t_d = t_q;
    if (clear_i) begin
      t_d = W'(1);
    end else if (hold_i) begin
      t_d = t_q;
    end else if (advance_i) begin
      t_d = {t_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    t_q <= t_d;
  end

  assign t_o       = t_q;
  assign at_last_o = t_q[W-1];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/timing controller: two-cycle IR fetch, then execute steps.
// FETCH_SEQ_INSTR_COUNT_EN builds the retired-instruction counter.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned T_WIDTH   = 12,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 T_Reset,
  input  logic                 Halt_Req,
  output logic [T_WIDTH-1:0]   T,
  output logic                 IR_Write,
  output logic                 IR_LH,
  output logic                 Mem_CS,
  output logic                 Mem_WR,
  output logic [1:0]           ARF_OutDSel,
  output logic [2:0]           ARF_RegSel,
  output logic [1:0]           ARF_FunSel,
  output logic                 Decode_Valid,
  output logic                 Halted,
  output logic                 Timeout,
  output logic [CNT_WIDTH-1:0] Instr_Count
);

  state_t state_q, state_d;
  logic   adv, clr, retire, tmo;
  logic   at_last;
  logic   timeout_q;
  logic   fetch;

  sequence_counter #(
    .W(T_WIDTH)
  ) u_seq_cnt (
    .clk_i    (Clock),
    .clear_i  (Reset | clr),
    .hold_i   (Stall),
    .advance_i(adv),
    .t_o      (T),
    .at_last_o(at_last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH_L;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt beats T_Reset, and T_Reset beats a last-step timeout.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    clr     = 1'b0;
    retire  = 1'b0;
    tmo     = 1'b0;
    if (!Stall) begin
      unique case (state_q)
        FETCH_L: begin
          state_d = FETCH_H;
          adv     = 1'b1;
        end
        FETCH_H: begin
          state_d = EXEC;
          adv     = 1'b1;
        end
        EXEC: begin
          if (Halt_Req) begin
            state_d = HALT;
            retire  = 1'b1;
          end else if (T_Reset) begin
            state_d = FETCH_L;
            clr     = 1'b1;
            retire  = 1'b1;
          end else if (at_last) begin
            state_d = HALT;
            tmo     = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
        HALT: begin
          state_d = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      timeout_q <= 1'b0;
    end else if (tmo) begin
      timeout_q <= 1'b1;
    end
  end

  always_comb begin
    fetch       = ((state_q == FETCH_L) ||
                   (state_q == FETCH_H)) && !Stall;
    IR_Write    = fetch;
    IR_LH       = fetch && (state_q == FETCH_H);
    Mem_CS      = fetch ? MEM_CS_ACTIVE : ~MEM_CS_ACTIVE;
    Mem_WR      = MEM_RD;
    ARF_OutDSel = ARF_OUTD_PC;
    ARF_RegSel  = fetch ? ARF_SEL_PC_ONLY : ARF_SEL_NONE;
    ARF_FunSel  = ARF_FUN_INC;
  end

  assign Decode_Valid = (state_q == EXEC) && T[2];
  assign Halted       = (state_q == HALT);
  assign Timeout      = timeout_q;

`ifdef FETCH_SEQ_INSTR_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign Instr_Count = count_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign Instr_Count   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  localparam int TW = 12;
  localparam int CW = 8;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Stall = 1'b0;
  logic          T_Reset = 1'b0;
  logic          Halt_Req = 1'b0;
  logic [TW-1:0] T;
  logic          IR_Write, IR_LH, Mem_CS, Mem_WR;
  logic [1:0]    ARF_OutDSel, ARF_FunSel;
  logic [2:0]    ARF_RegSel;
  logic          Decode_Valid, Halted, Timeout;
  logic [CW-1:0] Instr_Count;

  int vectors = 0;
  int errors  = 0;

  fetch_sequencer #(
    .T_WIDTH  (TW),
    .CNT_WIDTH(CW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Stall       (Stall),
    .T_Reset     (T_Reset),
    .Halt_Req    (Halt_Req),
    .T           (T),
    .IR_Write    (IR_Write),
    .IR_LH       (IR_LH),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .ARF_OutDSel (ARF_OutDSel),
    .ARF_RegSel  (ARF_RegSel),
    .ARF_FunSel  (ARF_FunSel),
    .Decode_Valid(Decode_Valid),
    .Halted      (Halted),
    .Timeout     (Timeout),
    .Instr_Count (Instr_Count)
  );

  always #5 Clock = ~Clock;

  function automatic logic [CW-1:0] ecnt(int n);
    return CNT_EN ? CW'(n) : '0;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [TW-1:0] et;
    do_reset();
    vectors++;
    if (T !== 12'h001) begin
      errors++;
      $display("FAIL rst_T got %h exp 001", T);
    end
    vectors++;
    if ({Halted, Timeout} !== 2'b00 || Instr_Count !== '0) begin
      errors++;
      $display("FAIL rst_flags got H%b TO%b C%0d exp 0 0 0",
               Halted, Timeout, Instr_Count);
    end
    for (int i = 1; i < TW; i++) begin
      tick();
      et = 12'(1) << i;
      vectors++;
      if (T !== et || Decode_Valid !== (i == 2) ||
          Mem_CS !== (i >= 2)) begin
        errors++;
        $display("FAIL walk_%0d got T%h DV%b CS%b exp T%h DV%b CS%b",
                 i, T, Decode_Valid, Mem_CS, et, i == 2, i >= 2);
      end
    end
    tick();
    vectors++;
    if (T !== 12'h800 || Halted !== 1'b1 || Timeout !== 1'b1 ||
        Mem_CS !== 1'b1) begin
      errors++;
      $display("FAIL timeout got T%h H%b TO%b CS%b exp 800 1 1 1",
               T, Halted, Timeout, Mem_CS);
    end
    T_Reset = 1'b1;
    tick();
    T_Reset = 1'b0;
    vectors++;
    if (T !== 12'h800 || Halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_sticky got T%h H%b exp 800 1", T, Halted);
    end
  endtask

  task automatic test_treset();
    do_reset();
    vectors++;
    if (IR_LH !== 1'b0 || Mem_CS !== 1'b0 || IR_Write !== 1'b1 ||
        ARF_RegSel !== 3'b011 || ARF_FunSel !== 2'b01 ||
        ARF_OutDSel !== 2'b00 || Mem_WR !== 1'b0) begin
      errors++;
      $display("FAIL fetch_l got LH%b CS%b W%b RS%b FS%b OD%b WR%b",
               IR_LH, Mem_CS, IR_Write, ARF_RegSel, ARF_FunSel,
               ARF_OutDSel, Mem_WR);
    end
    tick();
    vectors++;
    if (T !== 12'h002 || IR_LH !== 1'b1 || Mem_CS !== 1'b0 ||
        IR_Write !== 1'b1) begin
      errors++;
      $display("FAIL fetch_h got T%h LH%b CS%b W%b exp 002 1 0 1",
               T, IR_LH, Mem_CS, IR_Write);
    end
    tick();
    vectors++;
    if (T !== 12'h004 || Decode_Valid !== 1'b1 || IR_Write !== 1'b0 ||
        ARF_RegSel !== 3'b111 || Mem_CS !== 1'b1) begin
      errors++;
      $display("FAIL exec_t2 got T%h DV%b W%b RS%b CS%b",
               T, Decode_Valid, IR_Write, ARF_RegSel, Mem_CS);
    end
    T_Reset = 1'b1;
    tick();
    T_Reset = 1'b0;
    vectors++;
    if (T !== 12'h001 || Instr_Count !== ecnt(1) ||
        Decode_Valid !== 1'b0 || Timeout !== 1'b0) begin
      errors++;
      $display("FAIL retire got T%h C%0d DV%b TO%b exp 001 %0d 0 0",
               T, Instr_Count, Decode_Valid, Timeout, ecnt(1));
    end
  endtask

  task automatic test_stall();
    int pc_inc;
    pc_inc = 0;
    do_reset();
    if (ARF_RegSel === 3'b011 && ARF_FunSel === 2'b01) pc_inc++;
    tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ARF_RegSel === 3'b011) pc_inc++;
      vectors++;
      if (T !== 12'h002 || IR_Write !== 1'b0 || Mem_CS !== 1'b1 ||
          ARF_RegSel !== 3'b111) begin
        errors++;
        $display("FAIL stall_%0d got T%h W%b CS%b RS%b", i,
                 T, IR_Write, Mem_CS, ARF_RegSel);
      end
      tick();
    end
    Stall = 1'b0;
    #1;
    if (ARF_RegSel === 3'b011 && ARF_FunSel === 2'b01) pc_inc++;
    vectors++;
    if (T !== 12'h002 || IR_Write !== 1'b1 || IR_LH !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel got T%h W%b LH%b exp 002 1 1",
               T, IR_Write, IR_LH);
    end
    tick();
    if (ARF_RegSel === 3'b011) pc_inc++;
    vectors++;
    if (T !== 12'h004 || pc_inc != 2) begin
      errors++;
      $display("FAIL pc_inc got T%h n%0d exp 004 2", T, pc_inc);
    end
    Stall   = 1'b1;
    T_Reset = 1'b1;
    tick();
    vectors++;
    if (T !== 12'h004 || Decode_Valid !== 1'b1 ||
        Instr_Count !== '0) begin
      errors++;
      $display("FAIL stall_t2 got T%h DV%b C%0d exp 004 1 0",
               T, Decode_Valid, Instr_Count);
    end
    Stall = 1'b0;
    tick();
    T_Reset = 1'b0;
    vectors++;
    if (T !== 12'h001 || Instr_Count !== ecnt(1)) begin
      errors++;
      $display("FAIL stall_done got T%h C%0d exp 001 %0d",
               T, Instr_Count, ecnt(1));
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) tick();
    vectors++;
    if (T !== 12'h010) begin
      errors++;
      $display("FAIL at_t4 got %h exp 010", T);
    end
    Halt_Req = 1'b1;
    T_Reset  = 1'b1;
    tick();
    Halt_Req = 1'b0;
    vectors++;
    if (Halted !== 1'b1 || T !== 12'h010 || Timeout !== 1'b0 ||
        Instr_Count !== ecnt(1) || Mem_CS !== 1'b1) begin
      errors++;
      $display("FAIL halt got H%b T%h TO%b C%0d CS%b exp 1 010 0 %0d 1",
               Halted, T, Timeout, Instr_Count, Mem_CS, ecnt(1));
    end
    repeat (2) tick();
    T_Reset = 1'b0;
    vectors++;
    if (Halted !== 1'b1 || T !== 12'h010 || Instr_Count !== ecnt(1)) begin
      errors++;
      $display("FAIL halt_hold got H%b T%h C%0d", Halted, T, Instr_Count);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if (T !== 12'h001 || Halted !== 1'b0 || Instr_Count !== '0) begin
      errors++;
      $display("FAIL halt_exit got T%h H%b C%0d exp 001 0 0",
               T, Halted, Instr_Count);
    end
  endtask

  task automatic test_last_step_treset();
    do_reset();
    repeat (TW - 1) tick();
    T_Reset = 1'b1;
    tick();
    T_Reset = 1'b0;
    vectors++;
    if (T !== 12'h001 || Timeout !== 1'b0 || Halted !== 1'b0 ||
        Instr_Count !== ecnt(1)) begin
      errors++;
      $display("FAIL last_treset got T%h TO%b H%b C%0d exp 001 0 0 %0d",
               T, Timeout, Halted, Instr_Count, ecnt(1));
    end
  endtask

  task automatic test_midfetch_reset();
    do_reset();
    repeat (TW) tick();
    tick();
    T_Reset = 1'b0;
    vectors++;
    if (Timeout !== 1'b1) begin
      errors++;
      $display("FAIL pre_to got %b exp 1", Timeout);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (2) tick();
    T_Reset = 1'b1;
    tick();
    T_Reset = 1'b0;
    tick();
    vectors++;
    if (T !== 12'h002 || Instr_Count !== ecnt(1)) begin
      errors++;
      $display("FAIL pre_mid got T%h C%0d exp 002 %0d",
               T, Instr_Count, ecnt(1));
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if (T !== 12'h001 || IR_LH !== 1'b0 || Instr_Count !== '0 ||
        Timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got T%h LH%b C%0d TO%b exp 001 0 0 0",
               T, IR_LH, Instr_Count, Timeout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 1; n <= (1 << CW) + 1; n++) begin
      repeat (2) tick();
      T_Reset = 1'b1;
      tick();
      T_Reset = 1'b0;
      if (n == (1 << CW) - 1) begin
        vectors++;
        if (Instr_Count !== ecnt(n)) begin
          errors++;
          $display("FAIL cnt_max got %0d exp %0d", Instr_Count, ecnt(n));
        end
      end
    end
    vectors++;
    if (Instr_Count !== ecnt(1) || T !== 12'h001) begin
      errors++;
      $display("FAIL cnt_wrap got C%0d T%h exp %0d 001",
               Instr_Count, T, ecnt(1));
    end
  endtask

  initial begin
    test_reset();
    test_treset();
    test_stall();
    test_halt();
    test_last_step_treset();
    test_midfetch_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
